// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag and FSM types shared by the sequential ALU
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ASR,
    OP_ADC, OP_SBC, OP_MUL
  } opcode_e;
  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;
  typedef enum logic {IDLE, MUL} fsm_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add unsigned multiplier, one partial product per clock
module alu_mul_iter #(
  parameter int WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_p
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= CW'(WIDTH);
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_run && r_cnt != '0) begin
      r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
    end else
      r_run <= 1'b0;
  assign o_done = r_run && r_cnt == '0;
  assign o_p    = r_acc;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with persistent carry flag and iterative MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_negative,
  output logic             o_zero,
  output logic             o_busy
);
  fsm_e                r_state, w_state_nxt;
  logic                r_valid, r_c_flag;
  logic [WIDTH-1:0]    r_y;
  flags_t              r_flags;
  opcode_e             w_op;
  logic                w_accept, w_start, w_load_alu, w_load_mul, w_load;
  logic                w_inv, w_ci, w_big, w_arith, w_c, w_v, w_mul_done, w_mul_hi;
  logic [WIDTH-1:0]    w_addend, w_y, w_res_y;
  logic [WIDTH:0]      w_sum, w_shl, w_shr, w_asr;
  logic [2*WIDTH-1:0]  w_prod;
  flags_t              w_res_flags;
  assign w_op       = opcode_e'(i_opcode);
  assign o_busy     = r_state == MUL;
  assign o_in_ready = !o_busy && (!r_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_start    = w_accept && w_op == OP_MUL;
  assign w_load_alu = w_accept && w_op != OP_MUL;
  assign w_load_mul = o_busy && w_mul_done;
  assign w_load     = w_load_alu || w_load_mul;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_done  (w_mul_done),
    .o_p     (w_prod)
  );
  assign w_inv    = w_op == OP_SUB || w_op == OP_SBC;
  assign w_ci     = w_op == OP_ADD ? i_cin : w_op == OP_SUB ? 1'b1 : r_c_flag;
  assign w_addend = w_inv ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_ci};
  // one guard bit on each shifter catches the last bit shifted out
  assign w_shl    = {1'b0, i_a} << i_b;
  assign w_shr    = {i_a, 1'b0} >> i_b;
  assign w_asr    = $signed({i_a, 1'b0}) >>> i_b;
  assign w_big    = {1'b0, i_b} >= (WIDTH + 1)'(WIDTH);
  always_comb begin
    w_y     = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_arith = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
        w_y     = w_sum[WIDTH-1:0];
        w_c     = w_sum[WIDTH];
        w_v     = (i_a[WIDTH-1] == w_addend[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
        w_arith = 1'b1;
      end
      OP_AND: w_y = i_a & i_b;
      OP_OR:  w_y = i_a | i_b;
      OP_XOR: w_y = i_a ^ i_b;
      OP_SHL: begin
        w_y = w_shl[WIDTH-1:0];
        w_c = !w_big && w_shl[WIDTH];
      end
      OP_SHR: begin
        w_y = w_shr[WIDTH:1];
        w_c = !w_big && w_shr[0];
      end
      OP_ASR: begin
        w_y = w_asr[WIDTH:1];
        w_c = w_asr[0];
      end
      default: ;
    endcase
  end
  assign w_mul_hi    = |w_prod[2*WIDTH-1:WIDTH];
  assign w_res_y     = w_load_mul ? w_prod[WIDTH-1:0] : w_y;
  assign w_res_flags = {w_load_mul ? w_mul_hi : w_c, w_load_mul ? w_mul_hi : w_v,
                        w_res_y[WIDTH-1], ~|w_res_y};
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && w_start) w_state_nxt = MUL;
    else if (r_state == MUL && w_mul_done) w_state_nxt = IDLE;
  end
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_state_nxt;
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_valid  <= 1'b0;
      r_y      <= '0;
      r_flags  <= '0;
      r_c_flag <= 1'b0;
    end else begin
      r_valid <= w_load || (r_valid && !i_out_ready);
      if (w_load) begin
        r_y     <= w_res_y;
        r_flags <= w_res_flags;
      end
      if (w_load_alu && w_arith) r_c_flag <= w_c;
    end
  assign o_out_valid = r_valid;
  assign o_y         = r_y;
  assign o_cout      = r_flags.c;
  assign o_overflow  = r_flags.v;
  assign o_negative  = r_flags.n;
  assign o_zero      = r_flags.z;
endmodule
